// File: rtl/vga_pkg.sv
// Shared pixel type, scheduler state encoding and default screen geometry.
// ST_CLEAR exists only when VGA_SCHED_CLEAR_EN is defined.
package vga_pkg;

   localparam int unsigned X_MAX_DEF = 160;
   localparam int unsigned Y_MAX_DEF = 120;

   typedef struct packed {
      logic [6:0] y;
      logic [7:0] x;
      logic [7:0] brightness;
   } pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1
`ifdef VGA_SCHED_CLEAR_EN
      , ST_CLEAR = 2'd2
`endif
   } state_e;

   function automatic logic pix_in_bounds(input pixel_t p, input int unsigned xmax,
                                          input int unsigned ymax);
      return (32'(p.x) < xmax) && (32'(p.y) < ymax);
   endfunction

endpackage

// File: rtl/vga_pixel_sched_if.sv
// Bundle of the scheduler's requester and Avalon-MM signals (names match the scheduler ports).
// Clear handshake signals exist only when VGA_SCHED_CLEAR_EN is defined.
interface vga_pixel_sched_if #(
   parameter int unsigned CNT_W = 16
);
   logic              req0_valid;
   logic              req1_valid;
   logic              req0_ready;
   logic              req1_ready;
   logic [22:0]       req0_data;
   logic [22:0]       req1_data;
   logic              avm_write;
   logic [3:0]        avm_address;
   logic [31:0]       avm_writedata;
   logic              avm_waitrequest;
   logic [CNT_W-1:0]  drop_count;
`ifdef VGA_SCHED_CLEAR_EN
   logic              clear_start;
   logic              clear_busy;
`endif

   // master: the scheduler side (Avalon master, requester sink)
   modport master (
      input  req0_valid, req1_valid, req0_data, req1_data, avm_waitrequest,
      output req0_ready, req1_ready, avm_write, avm_address, avm_writedata, drop_count
`ifdef VGA_SCHED_CLEAR_EN
      , input clear_start, output clear_busy
`endif
   );

   modport slave (
      output req0_valid, req1_valid, req0_data, req1_data, avm_waitrequest,
      input  req0_ready, req1_ready, avm_write, avm_address, avm_writedata, drop_count
`ifdef VGA_SCHED_CLEAR_EN
      , output clear_start, input clear_busy
`endif
   );

endinterface

// File: rtl/vga_rr_arb2.sv
// Two-way round-robin arbiter; port 0 has priority out of reset.
module vga_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_q, last_d;  // 1 = port 1 was granted most recently

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (advance && (grant != 2'b00)) last_d = grant[1];
   end

   always_ff @(posedge clk) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/vga_pixel_sched.sv
// Two-requester pixel scheduler feeding an Avalon-MM VGA slave through a single output slot.
// Optional full-screen clear engine enabled by defining VGA_SCHED_CLEAR_EN.
module vga_pixel_sched
   import vga_pkg::*;
#(
   parameter int unsigned X_MAX = X_MAX_DEF,
   parameter int unsigned Y_MAX = Y_MAX_DEF,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [22:0]       req0_data,
   input  logic [22:0]       req1_data,
   output logic              avm_write,
   output logic [3:0]        avm_address,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   output logic [CNT_W-1:0]  drop_count
`ifdef VGA_SCHED_CLEAR_EN
   ,
   input  logic              clear_start,
   output logic              clear_busy
`endif
);

   state_e            state_q, state_d;
   pixel_t            pix_q, pix_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [1:0]        grant;
   pixel_t            pick;
   logic              slot_free, accept_en, accept, pick_ok;
`ifdef VGA_SCHED_CLEAR_EN
   logic              clear_req_q, clear_req_d;
`endif

   vga_rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .valid   ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   always_comb begin
      slot_free = (state_q == ST_IDLE) || ((state_q == ST_ISSUE) && !avm_waitrequest);
`ifdef VGA_SCHED_CLEAR_EN
      // A pending clear claims the slot as soon as it frees, so no pixel may slip in.
      accept_en = slot_free && !clear_req_q && !reset;
`else
      accept_en = slot_free && !reset;
`endif
      accept  = accept_en && (req0_valid || req1_valid);
      pick    = grant[1] ? pixel_t'(req1_data) : pixel_t'(req0_data);
      pick_ok = pix_in_bounds(pick, X_MAX, Y_MAX);
   end

   assign req0_ready    = accept_en && grant[0];
   assign req1_ready    = accept_en && grant[1];
   assign avm_write     = (state_q != ST_IDLE);
   assign avm_address   = '0;
   assign avm_writedata = {9'b0, pix_q};
   assign drop_count    = drop_q;
`ifdef VGA_SCHED_CLEAR_EN
   assign clear_busy    = clear_req_q || (state_q == ST_CLEAR);
`endif

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      drop_d  = drop_q;
`ifdef VGA_SCHED_CLEAR_EN
      clear_req_d = clear_req_q;
      if (clear_start && !clear_busy) clear_req_d = 1'b1;
`endif
      case (state_q)
         ST_IDLE, ST_ISSUE: begin
            if (slot_free) begin
               state_d = ST_IDLE;
`ifdef VGA_SCHED_CLEAR_EN
               if (clear_req_q) begin
                  state_d     = ST_CLEAR;
                  pix_d       = '0;
                  clear_req_d = 1'b0;
               end else
`endif
               if (accept && pick_ok) begin
                  state_d = ST_ISSUE;
                  pix_d   = pick;
               end
            end
         end
`ifdef VGA_SCHED_CLEAR_EN
         ST_CLEAR: begin
            // The slot register doubles as the sweep's x/y counter; brightness stays 0.
            if (!avm_waitrequest) begin
               if (32'(pix_q.x) == X_MAX - 1) begin
                  if (32'(pix_q.y) == Y_MAX - 1) begin
                     state_d = ST_IDLE;
                  end else begin
                     pix_d.x = '0;
                     pix_d.y = pix_q.y + 7'd1;
                  end
               end else begin
                  pix_d.x = pix_q.x + 8'd1;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      if (accept && !pick_ok && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pix_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         drop_q  <= drop_d;
      end
   end

`ifdef VGA_SCHED_CLEAR_EN
   always_ff @(posedge clk) begin
      if (reset) clear_req_q <= 1'b0;
      else       clear_req_q <= clear_req_d;
   end
`endif

endmodule

// File: tb/tb_vga_pixel_sched.sv
// Self-checking bench for vga_pixel_sched: vector table, hand sequences and a write scoreboard.
// Clear-engine sequence runs only when VGA_SCHED_CLEAR_EN is defined.
module tb_vga_pixel_sched;

   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_pixel_sched_if #(.CNT_W(CW)) bus ();

   vga_pixel_sched #(.X_MAX(160), .Y_MAX(120), .CNT_W(CW)) dut (
      .clk             (clk),
      .reset           (reset),
      .req0_valid      (bus.req0_valid),
      .req1_valid      (bus.req1_valid),
      .req0_ready      (bus.req0_ready),
      .req1_ready      (bus.req1_ready),
      .req0_data       (bus.req0_data),
      .req1_data       (bus.req1_data),
      .avm_write       (bus.avm_write),
      .avm_address     (bus.avm_address),
      .avm_writedata   (bus.avm_writedata),
      .avm_waitrequest (bus.avm_waitrequest),
      .drop_count      (bus.drop_count)
`ifdef VGA_SCHED_CLEAR_EN
      ,
      .clear_start     (bus.clear_start),
      .clear_busy      (bus.clear_busy)
`endif
   );

   typedef struct {
      logic        v0;
      logic [22:0] d0;
      logic        v1;
      logic [22:0] d1;
      logic        wr;
      logic        r0;
      logic        r1;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   logic [31:0] sb[$];
   int nchecks = 0;
   int nerr    = 0;
   int nwrites = 0;
   int exp_drop = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_wd = '0;

   function automatic logic [22:0] px(input int y, input int x, input int b);
      return {7'(y), 8'(x), 8'(b)};
   endfunction

   function automatic logic inb(input logic [22:0] d);
      return (d[22:16] < 7'd120) && (d[15:8] < 8'd160);
   endfunction

   function automatic vec_t mk(input logic v0, input logic [22:0] d0, input logic v1,
                               input logic [22:0] d1, input logic wr, input logic r0,
                               input logic r1);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.wr = wr; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_data  = '0;
      bus.avm_waitrequest = 1'b0;
`ifdef VGA_SCHED_CLEAR_EN
      bus.clear_start = 1'b0;
`endif
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
      sb.delete();
      exp_drop = 0;
   endtask

   task automatic model_accept(input logic [22:0] d);
      if (inb(d)) sb.push_back({9'b0, d});
      else if (exp_drop != 15) exp_drop++;
   endtask

   // Write monitor: completed writes are popped against the scoreboard; stalls must hold.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_hold_write", 32'(bus.avm_write), 32'd1);
            chk("stall_hold_data", bus.avm_writedata, prev_wd);
         end
         if (bus.avm_write && !bus.avm_waitrequest) begin
            nwrites++;
            chk("avm_address", 32'(bus.avm_address), 32'd0);
            if (sb.size() == 0) begin
               nchecks++;
               nerr++;
               $display("FAIL unexpected_write: got %h, required no write", bus.avm_writedata);
            end else begin
               chk("write_data", bus.avm_writedata, sb.pop_front());
            end
         end
         prev_stall = bus.avm_write && bus.avm_waitrequest;
         prev_wd    = bus.avm_writedata;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nw0;
      logic done;

      vecs[0]  = mk(1, px(1,1,1),     1, px(2,2,2),     0, 1, 0);
      vecs[1]  = mk(1, px(4,4,4),     1, px(2,2,2),     0, 0, 1);
      vecs[2]  = mk(1, px(4,4,4),     1, px(5,5,5),     0, 1, 0);
      vecs[3]  = mk(1, px(6,6,6),     1, px(5,5,5),     0, 0, 1);
      vecs[4]  = mk(0, '0,            0, '0,            0, 0, 0);
      vecs[5]  = mk(0, '0,            1, px(150,200,255), 0, 0, 1);
      vecs[6]  = mk(1, px(100,50,255), 0, '0,           0, 1, 0);
      vecs[7]  = mk(1, px(7,7,7),     0, '0,            1, 0, 0);
      vecs[8]  = mk(1, px(7,7,7),     0, '0,            1, 0, 0);
      vecs[9]  = mk(1, px(7,7,7),     0, '0,            1, 0, 0);
      vecs[10] = mk(1, px(7,7,7),     0, '0,            0, 1, 0);
      vecs[11] = mk(0, '0,            1, px(119,159,9), 0, 0, 1);
      vecs[12] = mk(1, px(0,160,1),   0, '0,            0, 1, 0);
      vecs[13] = mk(1, px(120,0,1),   0, '0,            0, 1, 0);
      vecs[14] = mk(0, '0,            0, '0,            0, 0, 0);
      vecs[15] = mk(1, px(8,8,8),     1, px(9,9,9),     1, 0, 1);
      vecs[16] = mk(1, px(8,8,8),     1, px(10,10,10),  1, 0, 0);
      vecs[17] = mk(1, px(8,8,8),     1, px(10,10,10),  0, 1, 0);
      vecs[18] = mk(0, '0,            0, '0,            0, 0, 0);
      vecs[19] = mk(0, '0,            0, '0,            0, 0, 0);

      // Reset state, with both requesters offering pixels.
      reset = 1'b1;
      idle_inputs();
      bus.req0_valid = 1'b1; bus.req0_data = px(3,3,3);
      bus.req1_valid = 1'b1; bus.req1_data = px(4,4,4);
      step();
      step();
      @(negedge clk);
      chk("rst_avm_write", 32'(bus.avm_write), 32'd0);
      chk("rst_writedata", bus.avm_writedata, 32'd0);
      chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
      chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
      chk("rst_drop", 32'(bus.drop_count), 32'd0);
`ifdef VGA_SCHED_CLEAR_EN
      chk("rst_clear_busy", 32'(bus.clear_busy), 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();

      // Vector table: arbitration, stalls, drops and bounds.
      nw0 = nwrites;
      for (int i = 0; i < NV; i++) begin
         step();
         bus.req0_valid = vecs[i].v0;
         bus.req0_data  = vecs[i].d0;
         bus.req1_valid = vecs[i].v1;
         bus.req1_data  = vecs[i].d1;
         bus.avm_waitrequest = vecs[i].wr;
         @(negedge clk);
         chk($sformatf("vec%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
         chk($sformatf("vec%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
         chk($sformatf("vec%0d_drop", i), 32'(bus.drop_count), 32'(exp_drop));
         if (vecs[i].r0) model_accept(vecs[i].d0);
         if (vecs[i].r1) model_accept(vecs[i].d1);
      end
      step();
      idle_inputs();
      step();
      @(negedge clk);
      chk("table_writes", 32'(nwrites - nw0), 32'd9);
      chk("table_sb_empty", 32'(sb.size()), 32'd0);
      chk("table_drop", 32'(bus.drop_count), 32'd3);

      // Single pixel, latency one, one-cycle write.
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_data = px(20,10,128);
      @(negedge clk);
      chk("lat_ready0", 32'(bus.req0_ready), 32'd1);
      chk("lat_no_write_yet", 32'(bus.avm_write), 32'd0);
      model_accept(bus.req0_data);
      step();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("lat_write", 32'(bus.avm_write), 32'd1);
      chk("lat_data", bus.avm_writedata, 32'h0014_0A80);
      step();
      @(negedge clk);
      chk("lat_one_cycle", 32'(bus.avm_write), 32'd0);

      // Three-cycle stall: data held, readies low, single completion.
      nw0 = nwrites;
      step();
      bus.req0_valid = 1'b1; bus.req0_data = px(100,50,255);
      @(negedge clk);
      chk("stall_accept", 32'(bus.req0_ready), 32'd1);
      model_accept(bus.req0_data);
      for (int c = 0; c < 3; c++) begin
         step();
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b1; bus.req1_data = px(30,30,30);
         bus.avm_waitrequest = 1'b1;
         @(negedge clk);
         chk("stall_write", 32'(bus.avm_write), 32'd1);
         chk("stall_data", bus.avm_writedata, 32'h0064_32FF);
         chk("stall_ready0", 32'(bus.req0_ready), 32'd0);
         chk("stall_ready1", 32'(bus.req1_ready), 32'd0);
      end
      step();
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("stall_last_data", bus.avm_writedata, 32'h0064_32FF);
      chk("stall_release_ready1", 32'(bus.req1_ready), 32'd1);
      model_accept(bus.req1_data);
      step();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("b2b_write", 32'(bus.avm_write), 32'd1);
      chk("b2b_data", bus.avm_writedata, 32'h001E_1E1E);
      step();
      @(negedge clk);
      chk("stall_writes", 32'(nwrites - nw0), 32'd2);

      // Reset during a stalled write abandons it.
      step();
      bus.req0_valid = 1'b1; bus.req0_data = px(0,200,0);
      @(negedge clk);
      chk("rmw_drop_accept", 32'(bus.req0_ready), 32'd1);
      model_accept(bus.req0_data);
      step();
      bus.req0_data = px(11,11,11);
      @(negedge clk);
      chk("rmw_accept", 32'(bus.req0_ready), 32'd1);
      chk("rmw_drop_before", 32'(bus.drop_count), 32'd1);
      model_accept(bus.req0_data);
      step();
      bus.req0_valid = 1'b0;
      bus.avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("rmw_stalled", 32'(bus.avm_write), 32'd1);
      step();
      reset = 1'b1;
      sb.delete();
      exp_drop = 0;
      step();
      @(negedge clk);
      chk("rmw_write_low", 32'(bus.avm_write), 32'd0);
      chk("rmw_drop_zero", 32'(bus.drop_count), 32'd0);
      step();
      reset = 1'b0;
      bus.avm_waitrequest = 1'b0;

      // Drop counter saturates rather than wrapping.
      for (int c = 0; c < 20; c++) begin
         step();
         bus.req0_valid = 1'b1; bus.req0_data = px(0,255,0);
         @(negedge clk);
         chk("sat_ready0", 32'(bus.req0_ready), 32'd1);
      end
      step();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("sat_drop", 32'(bus.drop_count), 32'hF);
      chk("sat_no_write", 32'(bus.avm_write), 32'd0);

`ifdef VGA_SCHED_CLEAR_EN
      // Full-screen clear with a short stall and an ignored second start.
      do_reset();
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++)
            sb.push_back({9'b0, 7'(y), 8'(x), 8'h00});
      nw0 = nwrites;
      @(negedge clk);
      chk("clr_busy_idle", 32'(bus.clear_busy), 32'd0);
      step();
      bus.clear_start = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 19500 && !done; k++) begin
         step();
         bus.req0_valid = (k < 4);
         bus.req0_data  = px(1,2,3);
         bus.avm_waitrequest = (k == 50) || (k == 51);
         bus.clear_start = (k == 100);
         @(negedge clk);
         if (k == 0) chk("clr_busy_rise", 32'(bus.clear_busy), 32'd1);
         if (k < 4) chk("clr_ready0_low", 32'(bus.req0_ready), 32'd0);
         if (!bus.clear_busy) done = 1'b1;
      end
      if (!done) chk("clr_timeout", 32'(bus.clear_busy), 32'd0);
      chk("clr_writes", 32'(nwrites - nw0), 32'd19200);
      chk("clr_sb_empty", 32'(sb.size()), 32'd0);
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         chk("clr_busy_stays_low", 32'(bus.clear_busy), 32'd0);
         chk("clr_no_resweep", 32'(bus.avm_write), 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule

// File: doc/vga_pixel_sched.md
VGA_PIXEL_SCHED -- requirements
Module: vga_pixel_sched

Interface
REQ-001 SHALL have parameter X_MAX, default 160, meaning exclusive upper bound on pixel x.
REQ-002 SHALL have parameter Y_MAX, default 120, meaning exclusive upper bound on pixel y.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the drop counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester has a pixel.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  pixel accepted this cycle when valid&ready.
REQ-008 SHALL have ports req0_data / req1_data  input  23  pixel {y[22:16], x[15:8], brightness[7:0]}.
REQ-009 SHALL have port avm_write  output  1  Avalon-MM write to the VGA slave.
REQ-010 SHALL have port avm_address  output  4  tied to 0.
REQ-011 SHALL have port avm_writedata  output  32  {9'b0, y, x, brightness}.
REQ-012 SHALL have port avm_waitrequest  input  1  slave stall.
REQ-013 SHALL have port drop_count  output  CNT_W  out-of-bounds pixels discarded.
REQ-014 SHALL have ports clear_start  input  1  and clear_busy  output  1 (present only with VGA_SCHED_CLEAR_EN).

Function
REQ-015 SHALL hold one output slot; FSM states IDLE (slot empty), ISSUE (avm_write=1), CLEAR (option only).
REQ-016 SHALL consider slot free when IDLE, or ISSUE with avm_waitrequest=0 this cycle.
REQ-017 SHALL assert ready only to the single granted requester, only while slot free and not CLEAR.
REQ-018 SHALL arbitrate round-robin: single valid wins; both valid, port not granted last wins; after reset, port 0 has priority.
REQ-019 SHALL present an accepted in-bounds pixel on avm_write/avm_writedata the cycle after acceptance (latency 1).
REQ-020 SHALL keep avm_write and avm_writedata stable while avm_waitrequest=1; write completes in a cycle with avm_write=1 and avm_waitrequest=0.
REQ-021 SHALL sustain one pixel per cycle when avm_waitrequest=0 (back-to-back accept and complete).
REQ-022 SHALL treat x>=X_MAX or y>=Y_MAX as out-of-bounds: still accepted (ready=1), never issued, drop_count+1 next cycle.
REQ-023 SHALL saturate drop_count at all-ones.
REQ-024 SHALL update the round-robin pointer on every acceptance, including dropped pixels.

Reset
REQ-025 SHALL on reset set: state IDLE, avm_write=0, avm_writedata=0, readies=0, drop_count=0, priority to port 0, clear_busy=0.
REQ-026 SHALL on reset mid-write deassert avm_write at the next edge, abandoning the in-flight pixel.
REQ-027 SHALL on reset mid-clear abort the sweep, clear_busy=0 next cycle.

Configuration
REQ-028 SHALL, with macro VGA_SCHED_CLEAR_EN defined, include a clear engine: clear_start pulse latched in IDLE/ISSUE; CLEAR entered once slot is free.
REQ-029 SHALL in CLEAR write brightness 0 to every pixel, x inner 0..X_MAX-1, y outer 0..Y_MAX-1, one write per non-stalled cycle, honouring waitrequest.
REQ-030 SHALL hold clear_busy=1 from the cycle after clear_start until the last clear write completes; return to IDLE then.
REQ-031 SHALL ignore clear_start while clear_busy=1 and force both readies to 0 during CLEAR.
REQ-032 SHALL, without VGA_SCHED_CLEAR_EN, omit clear_start, clear_busy, the CLEAR state and its counters.

Structure
REQ-033 SHALL place the pixel struct (y 7b, x 8b, brightness 8b), state enum, and default X_MAX/Y_MAX constants in package vga_pkg.
REQ-034 SHALL implement the two-way round-robin as sub-module vga_rr_arb2 (valid[1:0], advance in; grant[1:0] out).

Verification
REQ-035 SHALL cover: req0 {y=20,x=10,b=128}, waitrequest=0 -> avm_write=1 next cycle, writedata=0x0014_0A80, one cycle.
REQ-036 SHALL cover: both valid 4 cycles, waitrequest=0 -> grants alternate 0,1,0,1; four writes back-to-back.
REQ-037 SHALL cover: req1 {y=150,x=200,b=255} -> ready=1, no avm_write, drop_count 0->1.
REQ-038 SHALL cover: waitrequest=1 for 3 cycles on {y=100,x=50,b=255} -> writedata stable 4 cycles, readies low, one write completes.
REQ-039 SHALL cover: reset asserted during stalled write -> avm_write=0 and drop_count=0 next cycle.
REQ-040 SHALL cover (VGA_SCHED_CLEAR_EN): clear_start, waitrequest=0 -> 19200 writes of brightness 0, last {y=119,x=159}, clear_busy falls after it.
